// File: rtl/poly_note_player_pkg.sv
// Shared widths, mixer state encoding and sizing helpers for the
// polyphonic note player.
package poly_note_pkg;

    localparam int PHASE_W    = 22;
    localparam int STEP_W     = 20;
    localparam int ROM_ADDR_W = 10;

    typedef enum logic [2:0] {
        IDLE,
        FREQ,
        STEP,
        ACC,
        OUT
    } mix_state_t;

    function automatic int acc_width(input int nv, input int sw);
        return sw + $clog2(nv);
    endfunction

    function automatic int sel_width(input int nv);
        return (nv > 1) ? $clog2(nv) : 1;
    endfunction

endpackage

// File: rtl/poly_note_player_voice.sv
// One voice: note register, beat-driven duration counter, active flag and
// phase accumulator; POLY_NOTE_PLAYER_ENVELOPE_EN adds a beats-since-load decay.
module poly_voice
    import poly_note_pkg::*;
#(
    parameter int NOTE_W = 6,
    parameter int DUR_W  = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  play_enable,
    input  logic                  load,
    input  logic [NOTE_W-1:0]     note_in,
    input  logic [DUR_W-1:0]      dur_in,
    input  logic                  beat,
    input  logic                  advance,
    input  logic [STEP_W-1:0]     step,
    output logic [NOTE_W-1:0]     note,
    output logic                  active,
    output logic                  done,
    output logic [ROM_ADDR_W-1:0] sine_addr
`ifdef POLY_NOTE_PLAYER_ENVELOPE_EN
    ,
    output logic [2:0]            shift
`endif
);

    logic [DUR_W-1:0]   count;
    logic [PHASE_W-1:0] phase;
    logic [PHASE_W-1:0] phase_nxt;
    logic               tick;

    assign tick      = beat && play_enable && active;
    assign phase_nxt = advance ? phase + PHASE_W'(step) : phase;
    assign sine_addr = phase_nxt[PHASE_W-1 -: ROM_ADDR_W];

    // A load outranks a coincident beat or phase step.
    always_ff @(posedge clk) begin
        if (reset) begin
            note   <= '0;
            count  <= '0;
            phase  <= '0;
            active <= 1'b0;
            done   <= 1'b0;
        end else if (load) begin
            note   <= note_in;
            count  <= dur_in;
            phase  <= '0;
            active <= 1'b1;
            done   <= 1'b0;
        end else begin
            done <= tick && (count == '0);
            if (tick) begin
                if (count == '0) begin
                    active <= 1'b0;
                end else begin
                    count <= count - 1'b1;
                end
            end
            if (advance) begin
                phase <= phase_nxt;
            end
        end
    end

`ifdef POLY_NOTE_PLAYER_ENVELOPE_EN
    logic [5:0] elapsed;

    always_ff @(posedge clk) begin
        if (reset || load) begin
            elapsed <= '0;
        end else if (beat && play_enable && (elapsed != 6'd63)) begin
            elapsed <= elapsed + 6'd1;
        end
    end

    assign shift = elapsed[5:3];
`endif

endmodule

// File: rtl/poly_note_player.sv
// Polyphonic note player: per-voice note/duration/phase plus a sequential
// mixer sharing one frequency and one sine ROM. Optional: POLY_NOTE_PLAYER_ENVELOPE_EN.
module poly_note_player
    import poly_note_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int NOTE_W     = 6,
    parameter int DUR_W      = 6,
    parameter int SAMPLE_W   = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               play_enable,
    input  logic                               load_new_note,
    input  logic [sel_width(NUM_VOICES)-1:0]   voice_sel,
    input  logic [NOTE_W-1:0]                  note_to_load,
    input  logic [DUR_W-1:0]                   duration_to_load,
    input  logic                               beat,
    input  logic                               generate_next_sample,
    output logic [NUM_VOICES-1:0]              done_with_note,
    output logic [NUM_VOICES-1:0]              voice_active,
    output logic signed [SAMPLE_W-1:0]         sample_out,
    output logic                               new_sample_ready
);

    localparam int VSEL_W = sel_width(NUM_VOICES);
    localparam int SH     = $clog2(NUM_VOICES);
    localparam int ACC_W  = acc_width(NUM_VOICES, SAMPLE_W);

    mix_state_t                 state;
    mix_state_t                 state_nxt;
    logic [VSEL_W-1:0]          cur;
    logic signed [ACC_W-1:0]    acc;
    logic signed [ACC_W-1:0]    acc_sum;
    logic signed [ACC_W-1:0]    addend;
    logic                       mix_on;
    logic                       start;
    logic                       last;
    logic [STEP_W-1:0]          freq_q;
    logic signed [SAMPLE_W-1:0] sine_q;
    logic signed [SAMPLE_W-1:0] sample_q;
    logic [NOTE_W-1:0]          freq_addr;
    logic [ROM_ADDR_W-1:0]      sine_addr;

    logic [NUM_VOICES-1:0][NOTE_W-1:0]     note_v;
    logic [NUM_VOICES-1:0][ROM_ADDR_W-1:0] addr_v;
    logic [NUM_VOICES-1:0]                 load_v;
    logic [NUM_VOICES-1:0]                 adv_v;
`ifdef POLY_NOTE_PLAYER_ENVELOPE_EN
    logic [NUM_VOICES-1:0][2:0]            shift_v;
`endif

    for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
        assign load_v[i] = load_new_note && (voice_sel == VSEL_W'(i));
        assign adv_v[i]  = (state == STEP) && mix_on && (cur == VSEL_W'(i));

        poly_voice #(
            .NOTE_W (NOTE_W),
            .DUR_W  (DUR_W)
        ) u_voice (
            .clk         (clk),
            .reset       (reset),
            .play_enable (play_enable),
            .load        (load_v[i]),
            .note_in     (note_to_load),
            .dur_in      (duration_to_load),
            .beat        (beat),
            .advance     (adv_v[i]),
            .step        (freq_q),
            .note        (note_v[i]),
            .active      (voice_active[i]),
            .done        (done_with_note[i]),
            .sine_addr   (addr_v[i])
`ifdef POLY_NOTE_PLAYER_ENVELOPE_EN
            ,
            .shift       (shift_v[i])
`endif
        );
    end

    // Step size is the note index in units of 2^12 phase counts.
    function automatic logic [STEP_W-1:0] freq_rom(input logic [NOTE_W-1:0] n);
        return STEP_W'({n, 12'd0});
    endfunction

    // Parabolic half-wave approximation of a sine, peak 16384.
    function automatic logic signed [SAMPLE_W-1:0] sine_rom(
        input logic [ROM_ADDR_W-1:0] a
    );
        logic [19:0]        h;
        logic [19:0]        p;
        logic signed [31:0] s;
        h = {11'd0, a[8:0]};
        p = (h * (20'd512 - h)) >> 2;
        s = a[9] ? -$signed({12'd0, p}) : $signed({12'd0, p});
        return SAMPLE_W'(s);
    endfunction

    assign freq_addr = note_v[cur];
    assign sine_addr = addr_v[cur];

    always_ff @(posedge clk) begin
        freq_q <= freq_rom(freq_addr);
        sine_q <= sine_rom(sine_addr);
    end

    assign start = generate_next_sample && play_enable;
    assign last  = (cur == VSEL_W'(NUM_VOICES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = start ? FREQ : IDLE;
            FREQ:    state_nxt = STEP;
            STEP:    state_nxt = ACC;
            ACC:     state_nxt = last ? OUT : FREQ;
            OUT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        new_sample_ready = (state == OUT);
    end

`ifdef POLY_NOTE_PLAYER_ENVELOPE_EN
    assign addend = ACC_W'(sine_q >>> shift_v[cur]);
`else
    assign addend = ACC_W'(sine_q);
`endif

    assign acc_sum = acc + (mix_on ? addend : '0);

    // Voice audibility is frozen at FREQ so a late load cannot split a voice.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur      <= '0;
            acc      <= '0;
            mix_on   <= 1'b0;
            sample_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        cur <= '0;
                        acc <= '0;
                    end
                end
                FREQ: begin
                    mix_on <= voice_active[cur] && (note_v[cur] != '0);
                end
                ACC: begin
                    acc <= acc_sum;
                    if (last) begin
                        sample_q <= SAMPLE_W'(acc_sum >>> SH);
                    end else begin
                        cur <= cur + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sample_out = sample_q;

endmodule

// File: tb/tb_poly_note_player.sv
// Scoreboard bench for poly_note_player with four voices, default build.
module tb_poly_note_player;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              play_enable = 1'b1;
    logic              load_new_note = 1'b0;
    logic [1:0]        voice_sel = '0;
    logic [5:0]        note_to_load = '0;
    logic [5:0]        duration_to_load = '0;
    logic              beat = 1'b0;
    logic              generate_next_sample = 1'b0;
    logic [3:0]        done_with_note;
    logic [3:0]        voice_active;
    logic signed [15:0] sample_out;
    logic              new_sample_ready;

    poly_note_player #(
        .NUM_VOICES (4),
        .NOTE_W     (6),
        .DUR_W      (6),
        .SAMPLE_W   (16)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .play_enable          (play_enable),
        .load_new_note        (load_new_note),
        .voice_sel            (voice_sel),
        .note_to_load         (note_to_load),
        .duration_to_load     (duration_to_load),
        .beat                 (beat),
        .generate_next_sample (generate_next_sample),
        .done_with_note       (done_with_note),
        .voice_active         (voice_active),
        .sample_out           (sample_out),
        .new_sample_ready     (new_sample_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int smp;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;
    int   m_note[4];
    int   m_ph[4];
    bit   m_act[4];

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sine_m(input int a);
        int h;
        int p;
        h = a % 512;
        p = (h * (512 - h)) / 4;
        return (a >= 512) ? -p : p;
    endfunction

    always @(negedge clk) begin : mon
        exp_t e;
        if (!reset && new_sample_ready) begin
            check("ready_expected", (exp_q.size() > 0) ? 1 : 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sample", int'(sample_out), e.smp);
                check("latency", cyc, e.cyc);
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_model();
        for (int v = 0; v < 4; v++) begin
            m_note[v] = 0;
            m_ph[v]   = 0;
            m_act[v]  = 1'b0;
        end
        exp_q.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        clear_model();
    endtask

    task automatic load(input int v, input int n, input int d);
        voice_sel        = 2'(v);
        note_to_load     = 6'(n);
        duration_to_load = 6'(d);
        load_new_note    = 1'b1;
        step();
        load_new_note    = 1'b0;
        m_note[v] = n;
        m_act[v]  = 1'b1;
        m_ph[v]   = 0;
    endtask

    task automatic pulse_beat();
        beat = 1'b1;
        step();
        beat = 1'b0;
    endtask

    task automatic req();
        int   sum;
        exp_t e;
        sum = 0;
        for (int v = 0; v < 4; v++) begin
            if (m_act[v] && m_note[v] != 0) begin
                m_ph[v] = (m_ph[v] + m_note[v] * 4096) % 4194304;
                sum += sine_m(m_ph[v] / 4096);
            end
        end
        e.smp = sum >>> 2;
        e.cyc = cyc + 13;
        exp_q.push_back(e);
        generate_next_sample = 1'b1;
        step();
        generate_next_sample = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            step();
        end
        check("ready_timeout", exp_q.size(), 0);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        clear_model();
        step();
        do_reset();
        check("rst_sample", int'(sample_out), 0);
        check("rst_ready", int'(new_sample_ready), 0);
        check("rst_done", int'(done_with_note), 0);
        check("rst_active", int'(voice_active), 0);

        req();
        wait_idle();

        load(2, 10, 3);
        check("load_active", int'(voice_active), 4);
        for (int b = 0; b < 3; b++) begin
            pulse_beat();
            check("early_done", int'(done_with_note), 0);
            step();
        end
        pulse_beat();
        check("done_v2", int'(done_with_note), 4);
        check("inactive_v2", int'(voice_active), 0);
        step();
        check("done_pulse_end", int'(done_with_note), 0);
        m_act[2] = 1'b0;

        beat = 1'b1;
        load(0, 12, 0);
        beat = 1'b0;
        check("load_beat_done", int'(done_with_note), 0);
        check("load_beat_act", int'(voice_active), 1);
        step();
        pulse_beat();
        check("done_v0", int'(done_with_note), 1);
        check("inactive_v0", int'(voice_active), 0);
        m_act[0] = 1'b0;

        load(1, 7, 2);
        play_enable = 1'b0;
        for (int b = 0; b < 5; b++) begin
            pulse_beat();
            check("frozen_done", int'(done_with_note), 0);
        end
        check("frozen_active", int'(voice_active), 2);
        generate_next_sample = 1'b1;
        step();
        generate_next_sample = 1'b0;
        repeat (20) step();
        play_enable = 1'b1;
        pulse_beat();
        check("resume_b1", int'(done_with_note), 0);
        pulse_beat();
        check("resume_b2", int'(done_with_note), 0);
        pulse_beat();
        check("resume_done", int'(done_with_note), 2);

        do_reset();
        load(0, 5, 63);
        load(1, 5, 63);
        for (int k = 0; k < 3; k++) begin
            req();
            wait_idle();
        end
        load(3, 9, 40);
        load(2, 0, 40);
        for (int k = 0; k < 2; k++) begin
            req();
            wait_idle();
        end
        load(3, 63, 40);
        for (int k = 0; k < 10; k++) begin
            req();
            wait_idle();
        end

        req();
        repeat (3) step();
        generate_next_sample = 1'b1;
        step();
        generate_next_sample = 1'b0;
        wait_idle();
        repeat (20) step();

        req();
        repeat (4) step();
        reset = 1'b1;
        step();
        check("midrst_sample", int'(sample_out), 0);
        check("midrst_ready", int'(new_sample_ready), 0);
        reset = 1'b0;
        clear_model();
        repeat (20) step();
        load(0, 3, 10);
        req();
        wait_idle();
        check("after_rst_sample", int'(sample_out), 95);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
